image_buf_pp: RTL and testbench

//  Parametrised serial-to-parallel input-image buffer for the BNN input stage.

---
 rtl/image_buf_pp.sv | 106 ++++++++++
 tb/tb_image_buf_pp.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/image_buf_pp.sv
// Serial-to-parallel frame buffer for the BNN input stage: gathers INPUT_NUM pixel bits
// IN_W at a time and presents whole frames, optionally ping-ponging between two banks.
module image_buf_pp #(
    parameter int INPUT_NUM  = 784,
    parameter int IN_W       = 1,
    parameter bit DOUBLE_BUF = 1'b1
) (
    input  logic                 clk,
    input  logic                 xrst,
    input  logic                 rcv_ack,
    input  logic                 in_valid,
    input  logic [IN_W-1:0]      inputs,
    output logic                 rcv_req,
    input  logic                 snd_req,
    output logic                 snd_ack,
    output logic                 frame_valid,
    output logic [INPUT_NUM-1:0] outputs
);

    localparam int BEATS = INPUT_NUM / IN_W;
    localparam int NB    = DOUBLE_BUF ? 2 : 1;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    typedef enum logic { W_IDLE, W_RCV } wstate_e;
    typedef enum logic { R_IDLE, R_SND } rstate_e;

    logic [NB-1:0][INPUT_NUM-1:0] bank_q;
    logic [NB-1:0]                full_q;
    logic                         wr_bank_q, wr_bank_d;
    logic                         rd_bank_q, rd_bank_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic                         last_beat;
    wstate_e                      wstate_q;
    rstate_e                      rstate_q;
    logic                         snd_ack_q;

    // With a single bank the bank pointers are pinned at zero.
    assign wr_bank_d = (NB == 2) ? ~wr_bank_q : 1'b0;
    assign rd_bank_d = (NB == 2) ? ~rd_bank_q : 1'b0;
    assign last_beat = (cnt_q == LAST_BEAT);
    assign cnt_d     = last_beat ? '0 : cnt_q + 1'b1;

    assign rcv_req     = ((wstate_q == W_IDLE) && !full_q[wr_bank_q]) || (wstate_q == W_RCV);
    assign frame_valid = full_q[rd_bank_q];
    assign outputs     = bank_q[rd_bank_q];
    assign snd_ack     = snd_ack_q;

    // Full flags are shared by both FSMs, so both live in one block. A write completion
    // and a read release in the same cycle always hit different banks.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            bank_q    <= '0;
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            cnt_q     <= '0;
            wstate_q  <= W_IDLE;
            rstate_q  <= R_IDLE;
            snd_ack_q <= 1'b0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    if (rcv_ack && !full_q[wr_bank_q]) begin
                        wstate_q <= W_RCV;
                        cnt_q    <= '0;
                    end
                end
                W_RCV: begin
                    if (in_valid) begin
                        bank_q[wr_bank_q][cnt_q*IN_W +: IN_W] <= inputs;
                        cnt_q <= cnt_d;
                        if (last_beat) begin
                            full_q[wr_bank_q] <= 1'b1;
                            wr_bank_q         <= wr_bank_d;
                            wstate_q          <= W_IDLE;
                        end
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase

            case (rstate_q)
                R_IDLE: begin
                    if (snd_req && full_q[rd_bank_q]) begin
                        rstate_q  <= R_SND;
                        snd_ack_q <= 1'b1;
                    end
                end
                R_SND: begin
                    if (!snd_req) begin
                        rstate_q          <= R_IDLE;
                        snd_ack_q         <= 1'b0;
                        full_q[rd_bank_q] <= 1'b0;
                        rd_bank_q         <= rd_bank_d;
                    end
                end
                default: begin
                    rstate_q  <= R_IDLE;
                    snd_ack_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_buf_pp.sv
// Directed bench for image_buf_pp: three instances cover IN_W=1 ping-pong, IN_W=8
// ping-pong with stalled beats, and single-bank operation.
module tb_image_buf_pp;

    localparam int N = 784;

    logic clk = 1'b0;
    logic xrst;
    always #5 clk = ~clk;

    logic         a_ack, a_vld, a_in, a_sreq, a_rreq, a_sack, a_fv;
    logic [N-1:0] a_out;
    logic         b_ack, b_vld, b_sreq, b_rreq, b_sack, b_fv;
    logic [7:0]   b_in;
    logic [N-1:0] b_out;
    logic         c_ack, c_vld, c_in, c_sreq, c_rreq, c_sack, c_fv;
    logic [N-1:0] c_out;

    image_buf_pp #(.INPUT_NUM(N), .IN_W(1), .DOUBLE_BUF(1'b1)) u_a (
        .clk(clk), .xrst(xrst), .rcv_ack(a_ack), .in_valid(a_vld), .inputs(a_in),
        .rcv_req(a_rreq), .snd_req(a_sreq), .snd_ack(a_sack), .frame_valid(a_fv),
        .outputs(a_out));

    image_buf_pp #(.INPUT_NUM(N), .IN_W(8), .DOUBLE_BUF(1'b1)) u_b (
        .clk(clk), .xrst(xrst), .rcv_ack(b_ack), .in_valid(b_vld), .inputs(b_in),
        .rcv_req(b_rreq), .snd_req(b_sreq), .snd_ack(b_sack), .frame_valid(b_fv),
        .outputs(b_out));

    image_buf_pp #(.INPUT_NUM(N), .IN_W(1), .DOUBLE_BUF(1'b0)) u_c (
        .clk(clk), .xrst(xrst), .rcv_ack(c_ack), .in_valid(c_vld), .inputs(c_in),
        .rcv_req(c_rreq), .snd_req(c_sreq), .snd_ack(c_sack), .frame_valid(c_fv),
        .outputs(c_out));

    typedef struct {
        bit rcv_ack, snd_req, in_valid, in_bit;
        bit e_rreq, e_sack, e_fv;
    } vec_t;
    vec_t vecs[10];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // sel 0 drives instance A, sel 1 drives instance C
    task automatic drv(input int sel, input bit ra, input bit sr, input bit v, input bit d);
        if (sel == 0) {a_ack, a_sreq, a_vld, a_in} = {ra, sr, v, d};
        else          {c_ack, c_sreq, c_vld, c_in} = {ra, sr, v, d};
    endtask

    function automatic logic get_rreq(input int sel); return sel == 0 ? a_rreq : c_rreq; endfunction
    function automatic logic get_sack(input int sel); return sel == 0 ? a_sack : c_sack; endfunction
    function automatic logic get_fv(input int sel);   return sel == 0 ? a_fv   : c_fv;   endfunction

    task automatic send_frame(input int sel, input logic [N-1:0] d, input int nbeats, input bit sr);
        drv(sel, 1'b1, sr, 1'b0, 1'b0);
        @(negedge clk);
        for (int k = 0; k < nbeats; k++) begin
            drv(sel, 1'b0, sr, 1'b1, d[k]);
            @(negedge clk);
        end
        drv(sel, 1'b0, sr, 1'b0, 1'b0);
    endtask

    task automatic run_vecs(input int sel, input int lo, input int hi, input logic [N-1:0] hold);
        for (int i = lo; i <= hi; i++) begin
            drv(sel, vecs[i].rcv_ack, vecs[i].snd_req, vecs[i].in_valid, vecs[i].in_bit);
            @(negedge clk);
            chk($sformatf("v%0d_rcv_req", i), get_rreq(sel), vecs[i].e_rreq);
            chk($sformatf("v%0d_snd_ack", i), get_sack(sel), vecs[i].e_sack);
            chk($sformatf("v%0d_frame_valid", i), get_fv(sel), vecs[i].e_fv);
            if (sel == 1 && vecs[i].e_sack) chk($sformatf("v%0d_outputs_held", i), c_out, hold);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    logic [N-1:0] pat, ones, q, exp4;

    initial begin
        // Idle/reset vectors on A: nothing may move without rcv_ack
        vecs[0] = '{0,0,1,1, 1,0,0};
        vecs[1] = '{0,1,1,0, 1,0,0};
        vecs[2] = '{0,1,0,0, 1,0,0};
        vecs[3] = '{0,0,1,1, 1,0,0};
        // Single-bank C holding one full frame: rcv_ack ignored until release
        vecs[4] = '{1,0,0,0, 0,0,1};
        vecs[5] = '{1,1,0,0, 0,1,1};
        vecs[6] = '{0,1,0,0, 0,1,1};
        vecs[7] = '{1,0,0,0, 1,0,0};
        vecs[8] = '{0,1,0,0, 1,0,0};
        vecs[9] = '{0,0,0,0, 1,0,0};

        for (int k = 0; k < N; k++) begin
            pat[k]  = (k % 3 == 0);
            q[k]    = (k % 5 == 1);
            ones[k] = 1'b1;
        end

        xrst = 1'b0;
        drv(0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0);
        {b_ack, b_vld, b_sreq, b_in} = '0;
        repeat (3) @(negedge clk);
        chk("rst_a_outputs", a_out, '0);
        chk("rst_a_rcv_req", a_rreq, 1'b1);
        chk("rst_a_snd_ack", a_sack, 1'b0);
        chk("rst_a_frame_valid", a_fv, 1'b0);
        xrst = 1'b1;
        @(negedge clk);

        // Reset state persists until the first rcv_ack
        run_vecs(0, 0, 3, '0);
        chk("idle_a_outputs", a_out, '0);

        // IN_W=1 single frame
        send_frame(0, pat, N, 1'b0);
        chk("t2_frame_valid", a_fv, 1'b1);
        chk("t2_snd_ack_pre", a_sack, 1'b0);
        chk("t2_rcv_req", a_rreq, 1'b1);
        drv(0, 0, 1, 0, 0);
        @(negedge clk);
        chk("t2_snd_ack", a_sack, 1'b1);
        chk("t2_outputs", a_out, pat);
        drv(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t2_snd_ack_drop", a_sack, 1'b0);
        chk("t2_frame_valid_drop", a_fv, 1'b0);

        // Ping-pong: hold frame A while frame B arrives
        send_frame(0, pat, N, 1'b0);
        drv(0, 0, 1, 0, 0);
        @(negedge clk);
        chk("t3_snd_ack", a_sack, 1'b1);
        chk("t3_outputs_a", a_out, pat);
        send_frame(0, ones, N, 1'b1);
        chk("t3_rcv_req_full", a_rreq, 1'b0);
        chk("t3_outputs_still_a", a_out, pat);
        chk("t3_snd_ack_held", a_sack, 1'b1);
        drv(0, 1, 1, 0, 0);
        @(negedge clk);
        chk("t3_rcv_ack_ignored", a_rreq, 1'b0);
        drv(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t3_snd_ack_rel", a_sack, 1'b0);
        chk("t3_outputs_b", a_out, ones);
        chk("t3_frame_valid_b", a_fv, 1'b1);
        chk("t3_rcv_req_rel", a_rreq, 1'b1);
        drv(0, 0, 1, 0, 0);
        @(negedge clk);
        chk("t3_snd_ack_b", a_sack, 1'b1);
        drv(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t3_frame_valid_empty", a_fv, 1'b0);

        // IN_W=8 with stalled beats; gap inputs carry junk that must be ignored
        exp4 = '0;
        b_ack = 1'b1;
        @(negedge clk);
        b_ack = 1'b0;
        for (int k = 0; k < 98; k++) begin
            int gap;
            gap = (k == 50) ? 3 : int'($urandom_range(0, 2));
            b_vld = 1'b0;
            b_in  = 8'hA5;
            repeat (gap) @(negedge clk);
            if (k == 50) begin
                chk("t4_gap_outputs", b_out, exp4);
                chk("t4_gap_frame_valid", b_fv, 1'b0);
            end
            b_vld = 1'b1;
            b_in  = 8'(k);
            exp4[8*k +: 8] = 8'(k);
            @(negedge clk);
        end
        b_vld = 1'b0;
        chk("t4_frame_valid", b_fv, 1'b1);
        b_sreq = 1'b1;
        @(negedge clk);
        chk("t4_snd_ack", b_sack, 1'b1);
        chk("t4_outputs", b_out, exp4);
        b_sreq = 1'b0;
        @(negedge clk);
        chk("t4_frame_valid_drop", b_fv, 1'b0);

        // Single bank
        send_frame(1, q, N, 1'b0);
        chk("t5_rcv_req_full", c_rreq, 1'b0);
        chk("t5_frame_valid", c_fv, 1'b1);
        run_vecs(1, 4, 9, q);
        send_frame(1, ~q, N, 1'b0);
        chk("t5_frame2_valid", c_fv, 1'b1);
        drv(1, 0, 1, 0, 0);
        @(negedge clk);
        chk("t5_frame2_snd_ack", c_sack, 1'b1);
        chk("t5_frame2_outputs", c_out, ~q);
        drv(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("t5_frame2_release", c_rreq, 1'b1);

        // Reset mid-frame
        send_frame(0, ones, 400, 1'b0);
        chk("t6_pre_rst_rcv", a_rreq, 1'b1);
        xrst = 1'b0;
        @(negedge clk);
        chk("t6_rst_outputs", a_out, '0);
        chk("t6_rst_rcv_req", a_rreq, 1'b1);
        chk("t6_rst_snd_ack", a_sack, 1'b0);
        chk("t6_rst_frame_valid", a_fv, 1'b0);
        xrst = 1'b1;
        @(negedge clk);
        send_frame(0, ones, N, 1'b0);
        chk("t6_frame_valid", a_fv, 1'b1);
        chk("t6_outputs", a_out, ones);
        drv(0, 0, 1, 0, 0);
        @(negedge clk);
        chk("t6_snd_ack", a_sack, 1'b1);
        drv(0, 0, 0, 0, 0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
